// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, the hardwired-zero register index
// and the ALU operation select encodings used by the decode stage.
package cpu_pkg;

   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 4;
   localparam int ZERO_REG = 0;

   typedef enum logic [1:0] {
      ADD = 2'b00,
      AND = 2'b01,
      OR  = 2'b10,
      SUB = 2'b11
   } alu_sel_e;

endpackage

// File: rtl/alu_operand_regfile.sv
// Operand register file in front of the ALU: two registered read ports with
// write-first bypass, one writeback port, and the captured ALU carry flag.
module alu_operand_regfile
   import cpu_pkg::*;
#(
   parameter int DATA_W = cpu_pkg::DATA_W,
   parameter int ADDR_W = cpu_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic [ADDR_W-1:0] rs_a,
   input  logic [ADDR_W-1:0] rs_b,
   input  logic              we,
   input  logic [ADDR_W-1:0] rd,
   input  logic [DATA_W-1:0] wdata,
   input  logic              cf_we,
   input  logic              cf_in,
   output logic [DATA_W-1:0] op_a,
   output logic [DATA_W-1:0] op_b,
   output logic              carry_flag
);

   localparam int NUM_REGS = 2 ** ADDR_W;

   logic [DATA_W-1:0] regs [NUM_REGS];
   logic              wr_en;

   assign wr_en = we && (rd != ADDR_W'(ZERO_REG));

   // Value a register holds after this edge, so dependent ops need no bubble.
   function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] idx);
      if (idx == ADDR_W'(ZERO_REG)) begin
         return '0;
      end else if (we && (rd == idx)) begin
         return wdata;
      end else begin
         return regs[idx];
      end
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
         op_a       <= '0;
         op_b       <= '0;
         carry_flag <= 1'b0;
      end else begin
         if (wr_en) begin
            regs[rd] <= wdata;
         end
         if (!stall) begin
            op_a <= read_port(rs_a);
            op_b <= read_port(rs_b);
         end
         if (cf_we) begin
            carry_flag <= cf_in;
         end
      end
   end

endmodule

// File: tb/tb_alu_operand_regfile.sv
// Directed self-checking bench for alu_operand_regfile: reset, write/read,
// bypass, stall hold, carry flag, reset priority and back-to-back dependencies.
module tb_alu_operand_regfile;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        stall = 1'b0;
   logic [3:0]  rs_a = '0;
   logic [3:0]  rs_b = '0;
   logic        we = 1'b0;
   logic [3:0]  rd = '0;
   logic [31:0] wdata = '0;
   logic        cf_we = 1'b0;
   logic        cf_in = 1'b0;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        carry_flag;

   int errors = 0;
   int checks = 0;

   alu_operand_regfile dut (
      .clk        (clk),
      .reset      (reset),
      .stall      (stall),
      .rs_a       (rs_a),
      .rs_b       (rs_b),
      .we         (we),
      .rd         (rd),
      .wdata      (wdata),
      .cf_we      (cf_we),
      .cf_in      (cf_in),
      .op_a       (op_a),
      .op_b       (op_b),
      .carry_flag (carry_flag)
   );

   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1ns after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      we = 1'b0; cf_we = 1'b0; stall = 1'b0; reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      idle();
      rs_a = 4'd5; rs_b = 4'd9;
      tick();
      checks++;
      if (op_a !== 32'h0) begin errors++; $display("[TB] FAIL reset_op_a: got %h expected %h", op_a, 32'h0); end
      checks++;
      if (op_b !== 32'h0) begin errors++; $display("[TB] FAIL reset_op_b: got %h expected %h", op_b, 32'h0); end
      checks++;
      if (carry_flag !== 1'b0) begin errors++; $display("[TB] FAIL reset_carry: got %b expected %b", carry_flag, 1'b0); end
   endtask

   task automatic test_write_read();
      we = 1'b1; rd = 4'd3; wdata = 32'hDEAD_BEEF; rs_a = 4'd0; rs_b = 4'd0;
      tick();
      we = 1'b0; rs_a = 4'd3;
      tick();
      checks++;
      if (op_a !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL wr_rd_r3: got %h expected %h", op_a, 32'hDEAD_BEEF); end
      we = 1'b1; rd = 4'd0; wdata = 32'h1234; rs_b = 4'd0;
      tick();
      checks++;
      if (op_b !== 32'h0) begin errors++; $display("[TB] FAIL wr_r0_same_cycle: got %h expected %h", op_b, 32'h0); end
      we = 1'b0;
      tick();
      checks++;
      if (op_b !== 32'h0) begin errors++; $display("[TB] FAIL wr_r0_read: got %h expected %h", op_b, 32'h0); end
   endtask

   task automatic test_bypass();
      we = 1'b1; rd = 4'd7; wdata = 32'h0000_0055; rs_a = 4'd0; rs_b = 4'd0;
      tick();
      wdata = 32'h0000_00AA; rs_a = 4'd7; rs_b = 4'd7;
      tick();
      checks++;
      if (op_a !== 32'h0000_00AA) begin errors++; $display("[TB] FAIL bypass_a: got %h expected %h", op_a, 32'hAA); end
      checks++;
      if (op_b !== 32'h0000_00AA) begin errors++; $display("[TB] FAIL bypass_b: got %h expected %h", op_b, 32'hAA); end
      we = 1'b0;
      tick();
      checks++;
      if (op_a !== 32'h0000_00AA) begin errors++; $display("[TB] FAIL bypass_stored: got %h expected %h", op_a, 32'hAA); end
   endtask

   task automatic test_stall();
      we = 1'b1; rd = 4'd2; wdata = 32'h11; rs_a = 4'd0; rs_b = 4'd7;
      tick();
      we = 1'b0; rs_a = 4'd2;
      tick();
      checks++;
      if (op_a !== 32'h11) begin errors++; $display("[TB] FAIL stall_pre: got %h expected %h", op_a, 32'h11); end
      stall = 1'b1; we = 1'b1; rd = 4'd2; wdata = 32'h22; rs_b = 4'd3;
      tick();
      checks++;
      if (op_a !== 32'h11) begin errors++; $display("[TB] FAIL stall_hold_a: got %h expected %h", op_a, 32'h11); end
      checks++;
      if (op_b !== 32'hAA) begin errors++; $display("[TB] FAIL stall_hold_b: got %h expected %h", op_b, 32'hAA); end
      we = 1'b0;
      tick();
      checks++;
      if (op_a !== 32'h11) begin errors++; $display("[TB] FAIL stall_hold2_a: got %h expected %h", op_a, 32'h11); end
      stall = 1'b0;
      tick();
      checks++;
      if (op_a !== 32'h22) begin errors++; $display("[TB] FAIL stall_release_a: got %h expected %h", op_a, 32'h22); end
      checks++;
      if (op_b !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL stall_release_b: got %h expected %h", op_b, 32'hDEAD_BEEF); end
   endtask

   task automatic test_carry();
      cf_we = 1'b1; cf_in = 1'b1;
      tick();
      checks++;
      if (carry_flag !== 1'b1) begin errors++; $display("[TB] FAIL carry_set: got %b expected %b", carry_flag, 1'b1); end
      cf_we = 1'b0; cf_in = 1'b0;
      tick();
      checks++;
      if (carry_flag !== 1'b1) begin errors++; $display("[TB] FAIL carry_hold: got %b expected %b", carry_flag, 1'b1); end
      stall = 1'b1; cf_we = 1'b1; cf_in = 1'b0;
      tick();
      checks++;
      if (carry_flag !== 1'b0) begin errors++; $display("[TB] FAIL carry_during_stall: got %b expected %b", carry_flag, 1'b0); end
      stall = 1'b0; cf_in = 1'b1;
      tick();
      cf_we = 1'b0; reset = 1'b1;
      tick();
      checks++;
      if (carry_flag !== 1'b0) begin errors++; $display("[TB] FAIL carry_reset: got %b expected %b", carry_flag, 1'b0); end
      idle();
   endtask

   task automatic test_reset_priority();
      we = 1'b1; rd = 4'd4; wdata = 32'h44; rs_a = 4'd4; rs_b = 4'd0;
      cf_we = 1'b1; cf_in = 1'b1;
      tick();
      we = 1'b1; rd = 4'd3; wdata = 32'h33; cf_we = 1'b0; rs_a = 4'd4; rs_b = 4'd3;
      tick();
      checks++;
      if (op_a !== 32'h44) begin errors++; $display("[TB] FAIL prio_setup_a: got %h expected %h", op_a, 32'h44); end
      reset = 1'b1; stall = 1'b1; we = 1'b1; rd = 4'd4; wdata = 32'hFFFF_FFFF;
      cf_we = 1'b1; cf_in = 1'b1;
      tick();
      checks++;
      if (op_a !== 32'h0) begin errors++; $display("[TB] FAIL prio_op_a: got %h expected %h", op_a, 32'h0); end
      checks++;
      if (op_b !== 32'h0) begin errors++; $display("[TB] FAIL prio_op_b: got %h expected %h", op_b, 32'h0); end
      checks++;
      if (carry_flag !== 1'b0) begin errors++; $display("[TB] FAIL prio_carry: got %b expected %b", carry_flag, 1'b0); end
      idle();
      rs_a = 4'd4; rs_b = 4'd3;
      tick();
      checks++;
      if (op_a !== 32'h0) begin errors++; $display("[TB] FAIL prio_r4: got %h expected %h", op_a, 32'h0); end
      checks++;
      if (op_b !== 32'h0) begin errors++; $display("[TB] FAIL prio_r3: got %h expected %h", op_b, 32'h0); end
   endtask

   task automatic test_back_to_back();
      we = 1'b1; rd = 4'd5; wdata = 32'h1; rs_a = 4'd5; rs_b = 4'd0;
      tick();
      checks++;
      if (op_a !== 32'h1) begin errors++; $display("[TB] FAIL b2b_first: got %h expected %h", op_a, 32'h1); end
      rd = 4'd6; wdata = 32'h2; rs_a = 4'd5; rs_b = 4'd6;
      tick();
      checks++;
      if (op_a !== 32'h1) begin errors++; $display("[TB] FAIL b2b_a: got %h expected %h", op_a, 32'h1); end
      checks++;
      if (op_b !== 32'h2) begin errors++; $display("[TB] FAIL b2b_b: got %h expected %h", op_b, 32'h2); end
      rd = 4'd15; wdata = 32'hCAFE_F00D; rs_a = 4'd15; rs_b = 4'd6;
      tick();
      checks++;
      if (op_a !== 32'hCAFE_F00D) begin errors++; $display("[TB] FAIL b2b_r15: got %h expected %h", op_a, 32'hCAFE_F00D); end
      we = 1'b0; rs_a = 4'd6; rs_b = 4'd15;
      tick();
      checks++;
      if (op_a !== 32'h2) begin errors++; $display("[TB] FAIL b2b_r6_stored: got %h expected %h", op_a, 32'h2); end
      checks++;
      if (op_b !== 32'hCAFE_F00D) begin errors++; $display("[TB] FAIL b2b_r15_stored: got %h expected %h", op_b, 32'hCAFE_F00D); end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_bypass();
      test_stall();
      test_carry();
      test_reset_priority();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_operand_regfile.md
Name: alu_operand_regfile

Overview:
- Register file directly upstream of the 32-bit ALU; supplies the ALU's A and B operands.
- Two registered read ports and one write port. The write port takes the ALU result back from writeback.
- Holds a carry flag captured from the ALU carry-out.
- Read data is launched one cycle after the address. Same-cycle write data is bypassed, so back-to-back dependent ALU ops need no bubble.

Parameters:
- DATA_W, 32, operand/result width (matches ALU A/B/out).
- ADDR_W, 4, register index width; 2**ADDR_W registers (16).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  1 = hold operand outputs (reads frozen); writes still occur.
- rs_a  in  ADDR_W  read index for operand A.
- rs_b  in  ADDR_W  read index for operand B.
- we  in  1  write enable.
- rd  in  ADDR_W  write index.
- wdata  in  DATA_W  write data (ALU out from writeback).
- cf_we  in  1  carry-flag write enable.
- cf_in  in  1  carry value (ALU cOut).
- op_a  out  DATA_W  registered operand A to ALU input A.
- op_b  out  DATA_W  registered operand B to ALU input B.
- carry_flag  out  1  registered carry flag.

Behaviour:
- Storage: 2**ADDR_W words of DATA_W. Register 0 is hardwired zero: writes to rd=0 are silently dropped, and reads of index 0 return 0.
- Write: at posedge with we=1, reset=0 and rd!=0, regs[rd] <= wdata. The write is independent of stall.
- Read, latency 1: at posedge with reset=0 and stall=0:
  - op_a <= 0 if rs_a=0;
  - else op_a <= wdata if (we=1 and rd=rs_a);
  - else op_a <= regs[rs_a].
  - op_b is computed identically from rs_b.
- Bypass is write-first: the value launched equals the value the register holds after this edge.
- Stall: with stall=1, op_a/op_b hold their previous values, even if the register they were read from is written this cycle. No re-read occurs on stall release; the next non-stalled edge samples the current rs_a/rs_b.
- Same index on both ports (rs_a=rs_b): both outputs get the same value, bypass included.
- Carry: at posedge with cf_we=1 and reset=0, carry_flag <= cf_in. Otherwise it holds. Independent of stall and we.
- Reset (synchronous, dominant): at posedge with reset=1, all registers, op_a, op_b and carry_flag <= 0. Any we/cf_we in the same cycle is discarded. Reset asserted mid-stall clears everything; stall is irrelevant during reset.
- Out-of-range indices cannot occur (full 2**ADDR_W decode). No X may propagate from unwritten registers, because all are reset to 0.
- No combinational path from any input to any output. All outputs are flops.

Decomposition:
- Shared package (cpu_pkg) holds:
  - DATA_W=32 and ADDR_W=4 defaults;
  - ZERO_REG=0;
  - the ALU select encodings: ADD=2'b00, AND=2'b01, OR=2'b10, SUB=2'b11. The decode stage driving both blocks uses these.
- No sub-module. The per-port read/bypass mux is a single local function or two identical always blocks.

Test Plan:
- Reset then read: assert reset 1 cycle, then rs_a=5, rs_b=9 -> next cycle op_a=0, op_b=0, carry_flag=0.
- Write then read: we=1, rd=3, wdata=32'hDEAD_BEEF; next cycle rs_a=3 -> op_a=32'hDEAD_BEEF one cycle later. rd=0 with wdata=32'h1234 -> reading r0 gives 0.
- Bypass: same cycle we=1, rd=7, wdata=32'h0000_00AA, rs_a=7, rs_b=7 -> after that edge op_a=op_b=32'h0000_00AA, not the old r7 value.
- Stall hold: op_a=32'h11 from r2; assert stall and write r2=32'h22 -> op_a stays 32'h11. Release stall -> next edge op_a=32'h22.
- Carry: cf_we=1, cf_in=1 -> carry_flag=1. Then cf_we=0, cf_in=0 -> stays 1. reset -> 0.
- Reset priority: reset=1 with we=1, rd=4, wdata=32'hFFFF_FFFF and cf_we=1, cf_in=1 -> afterwards r4 reads 0 and carry_flag=0.
